// File: rtl/core_sequencer.sv
// Multi-cycle stage sequencer: walks FETCH/DECODE/EXEC/MEM/WRITE, owns the PC and the retired count,
// skips unneeded stages, waits on data memory and traps halt / memory-timeout into a sticky HALTED state.
module core_sequencer #(
  parameter int PC_W        = 10,
  parameter int CNT_W       = 32,
  parameter int RESET_PC    = 0,
  parameter int MEM_TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             halt,
  input  logic             mem_op,
  input  logic             wb_en,
  input  logic             branch_taken,
  input  logic [PC_W-1:0]  branch_target,
  input  logic             mem_ready,
  output logic [2:0]       state,
  output logic [PC_W-1:0]  pc,
  output logic             reg_we,
  output logic [CNT_W-1:0] retired,
  output logic             running,
  output logic             halted,
  output logic             fault
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WRITE  = 3'd4,
    S_IDLE   = 3'd5,
    S_HALTED = 3'd6
  } state_t;

  localparam int WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MEM_TIMEOUT - 1);

  state_t            state_q, state_d;
  logic [PC_W-1:0]   pc_q, next_pc_q, exec_npc;
  logic [CNT_W-1:0]  retired_q;
  logic [WAIT_W-1:0] wait_q;
  logic              wb_q, fault_q;
  logic              retire, timeout;

  // Branch targets are word-aligned by dropping the low two address bits.
  assign exec_npc = branch_taken ? (branch_target & ~PC_W'(3)) : (pc_q + PC_W'(4));

  always_comb begin
    state_d = state_q;
    retire  = 1'b0;
    timeout = 1'b0;
    case (state_q)
      S_IDLE:   if (start) state_d = S_FETCH;
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: state_d = halt ? S_HALTED : S_EXEC;
      S_EXEC: begin
        if (mem_op)     state_d = S_MEM;
        else if (wb_en) state_d = S_WRITE;
        else begin
          retire  = 1'b1;
          state_d = S_FETCH;
        end
      end
      S_MEM: begin
        if (mem_ready) begin
          if (wb_q) state_d = S_WRITE;
          else begin
            retire  = 1'b1;
            state_d = S_FETCH;
          end
        end else if (wait_q == WAIT_MAX) begin
          timeout = 1'b1;
          state_d = S_HALTED;
        end
      end
      S_WRITE: begin
        retire  = 1'b1;
        state_d = S_FETCH;
      end
      S_HALTED: state_d = S_HALTED;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      pc_q      <= PC_W'(RESET_PC);
      next_pc_q <= '0;
      retired_q <= '0;
      wait_q    <= '0;
      wb_q      <= 1'b0;
      fault_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == S_EXEC) begin
        next_pc_q <= exec_npc;
        wb_q      <= wb_en;
        wait_q    <= '0;
      end else if (state_q == S_MEM && !mem_ready) begin
        wait_q <= wait_q + WAIT_W'(1);
      end
      // An ALU-only instruction retires straight out of EXEC, before next_pc_q is loaded.
      if (retire) begin
        pc_q      <= (state_q == S_EXEC) ? exec_npc : next_pc_q;
        retired_q <= retired_q + CNT_W'(1);
      end
      if (timeout) fault_q <= 1'b1;
    end
  end

  assign state   = state_q;
  assign pc      = pc_q;
  assign retired = retired_q;
  assign fault   = fault_q;
  assign reg_we  = (state_q == S_WRITE);
  assign halted  = (state_q == S_HALTED);
  assign running = (state < 3'd5);

endmodule

// File: tb/tb_core_sequencer.sv
// Directed bench for core_sequencer: per-cycle expectations are queued as stimulus is driven
// and popped/compared one cycle later against a small PC/retired model.
module tb_core_sequencer;

  logic        clk = 1'b0;
  logic        rst, start, halt, mem_op, wb_en, branch_taken, mem_ready;
  logic [9:0]  branch_target;
  logic [2:0]  state;
  logic [9:0]  pc;
  logic        reg_we, running, halted, fault;
  logic [31:0] retired;

  core_sequencer #(.PC_W(10), .CNT_W(32), .RESET_PC(0), .MEM_TIMEOUT(255)) dut (
    .clk(clk), .rst(rst), .start(start), .halt(halt), .mem_op(mem_op), .wb_en(wb_en),
    .branch_taken(branch_taken), .branch_target(branch_target), .mem_ready(mem_ready),
    .state(state), .pc(pc), .reg_we(reg_we), .retired(retired), .running(running),
    .halted(halted), .fault(fault)
  );

  always #5 clk = ~clk;

  typedef struct {
    int st;
    int pcv;
    int we;
    int ret;
    int flt;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  int   cycle  = 0;
  int   m_pc   = 0;
  int   m_ret  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s cyc=%0d: observed=%0h expected=%0h", tag, cycle, obs, expv);
    end
  endtask

  // Queue the expectation for the state reached after the next edge, then advance and compare.
  task automatic cyc(input int st, input int pcv, input int we, input int ret, input int flt);
    exp_t e;
    exp_q.push_back('{st, pcv, we, ret, flt});
    @(posedge clk);
    #1;
    cycle++;
    e = exp_q.pop_front();
    chk("state",   {29'd0, state},  e.st);
    chk("pc",      {22'd0, pc},     e.pcv);
    chk("reg_we",  {31'd0, reg_we}, e.we);
    chk("retired", retired,         e.ret);
    chk("fault",   {31'd0, fault},  e.flt);
    chk("running", {31'd0, running}, (e.st < 5) ? 1 : 0);
    chk("halted",  {31'd0, halted},  (e.st == 6) ? 1 : 0);
  endtask

  // Entered with the DUT in FETCH; leaves it in FETCH of the next instruction.
  task automatic do_instr(input bit mop, input bit wb, input bit br, input int tgt, input int waits);
    int npc;
    cyc(1, m_pc, 0, m_ret, 0);
    halt = 1'b0;
    cyc(2, m_pc, 0, m_ret, 0);
    mem_op = mop; wb_en = wb; branch_taken = br; branch_target = tgt[9:0];
    npc = br ? (tgt & 'h3FC) : ((m_pc + 4) & 'h3FF);
    if (mop) begin
      cyc(3, m_pc, 0, m_ret, 0);
      mem_op = 1'b0; wb_en = 1'b0; branch_taken = 1'b0; branch_target = '0;
      mem_ready = 1'b0;
      repeat (waits) cyc(3, m_pc, 0, m_ret, 0);
      mem_ready = 1'b1;
    end
    if (wb) begin
      cyc(4, m_pc, 1, m_ret, 0);
      mem_ready = 1'b0;
    end
    mem_op = 1'b0; wb_en = 1'b0; branch_taken = 1'b0; branch_target = '0;
    m_pc  = npc;
    m_ret = m_ret + 1;
    cyc(0, m_pc, 0, m_ret, 0);
    mem_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; halt = 1'b0; mem_op = 1'b0; wb_en = 1'b0;
    branch_taken = 1'b0; branch_target = '0; mem_ready = 1'b0;
    #2;
    cyc(5, 0, 0, 0, 0);
    rst = 1'b0;
    cyc(5, 0, 0, 0, 0);

    // ALU with writeback
    start = 1'b1;
    cyc(0, 0, 0, 0, 0);
    start = 1'b0;
    do_instr(1'b0, 1'b1, 1'b0, 0, 0);
    // load with three wait cycles
    do_instr(1'b1, 1'b1, 1'b0, 0, 3);
    // store with taken branch to an unaligned target
    do_instr(1'b1, 1'b0, 1'b1, 'h3FE, 0);
    // ALU, no writeback, PC wraps
    do_instr(1'b0, 1'b0, 1'b0, 0, 0);

    // halt in DECODE; start pulses ignored; reset recovers
    cyc(1, m_pc, 0, m_ret, 0);
    halt = 1'b1;
    cyc(6, m_pc, 0, m_ret, 0);
    halt = 1'b0; start = 1'b1;
    cyc(6, m_pc, 0, m_ret, 0);
    start = 1'b0;
    cyc(6, m_pc, 0, m_ret, 0);
    rst = 1'b1;
    m_pc = 0; m_ret = 0;
    cyc(5, 0, 0, 0, 0);
    rst = 1'b0;

    // memory timeout: 255 MEM cycles with mem_ready low
    start = 1'b1;
    cyc(0, 0, 0, 0, 0);
    start = 1'b0;
    cyc(1, 0, 0, 0, 0);
    cyc(2, 0, 0, 0, 0);
    mem_op = 1'b1; wb_en = 1'b1;
    cyc(3, 0, 0, 0, 0);
    mem_op = 1'b0; wb_en = 1'b0; mem_ready = 1'b0;
    repeat (254) cyc(3, 0, 0, 0, 0);
    cyc(6, 0, 0, 0, 1);
    cyc(6, 0, 0, 0, 1);
    rst = 1'b1;
    cyc(5, 0, 0, 0, 0);
    rst = 1'b0;

    // reset in the middle of a MEM wait
    start = 1'b1;
    cyc(0, 0, 0, 0, 0);
    start = 1'b0;
    do_instr(1'b0, 1'b0, 1'b0, 0, 0);
    cyc(1, m_pc, 0, m_ret, 0);
    cyc(2, m_pc, 0, m_ret, 0);
    mem_op = 1'b1; wb_en = 1'b1;
    cyc(3, m_pc, 0, m_ret, 0);
    mem_op = 1'b0; wb_en = 1'b0;
    cyc(3, m_pc, 0, m_ret, 0);
    rst = 1'b1;
    m_pc = 0; m_ret = 0;
    cyc(5, 0, 0, 0, 0);
    rst = 1'b0;
    cyc(5, 0, 0, 0, 0);

    // fresh instruction after the mid-MEM reset
    start = 1'b1;
    cyc(0, 0, 0, 0, 0);
    start = 1'b0;
    do_instr(1'b1, 1'b0, 1'b0, 0, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
